// File: rtl/hex_fmt_pkg.sv
// Shared state encoding and ASCII constants for the hex line formatter.
// The PREFIX states are only decoded when HEXFMT_PREFIX_EN is defined.
package hex_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFIX0 = 3'd1,
        ST_PREFIX1 = 3'd2,
        ST_DIGIT   = 3'd3,
        ST_CR      = 3'd4,
        ST_LF      = 3'd5
    } fmt_state_e;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_X  = 8'h78;
    localparam logic [7:0] CHAR_A  = 8'h41;

endpackage

// File: rtl/nibble_to_ascii.sv
// Maps one nibble to its uppercase ASCII hex digit.
module nibble_to_ascii
    import hex_fmt_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii = CHAR_0 + {4'h0, i_nibble};
        end else begin
            o_ascii = CHAR_A + {4'h0, i_nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_line_formatter.sv
// Prints one accepted word as uppercase hex followed by CR LF into a TX FIFO.
// Define HEXFMT_PREFIX_EN to start every line with "0x".
module hex_line_formatter
    import hex_fmt_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_busy,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [7:0]            fifo_din
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NIBBLES - 1);

    fmt_state_e            r_state;
    fmt_state_e            w_next;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_accept;
    logic [3:0]            w_nibble;
    logic [7:0]            w_digit;

    assign w_accept = i_valid & (r_state == ST_IDLE);
    assign fifo_wr  = (r_state != ST_IDLE) & ~fifo_full & ~rst;
    assign w_nibble = 4'(r_data >> {r_count, 2'b00});

    nibble_to_ascii u_nibble_to_ascii (
        .i_nibble (w_nibble),
        .o_ascii  (w_digit)
    );

    // Everything holds while the FIFO is full; the counter only moves on digit writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data  <= i_data;
                r_count <= CNT_LOAD;
            end else if (fifo_wr && (r_state == ST_DIGIT) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef HEXFMT_PREFIX_EN
                if (i_valid) w_next = ST_PREFIX0;
`else
                if (i_valid) w_next = ST_DIGIT;
`endif
            end
`ifdef HEXFMT_PREFIX_EN
            ST_PREFIX0: if (fifo_wr) w_next = ST_PREFIX1;
            ST_PREFIX1: if (fifo_wr) w_next = ST_DIGIT;
`endif
            ST_DIGIT:   if (fifo_wr && (r_count == '0)) w_next = ST_CR;
            ST_CR:      if (fifo_wr) w_next = ST_LF;
            ST_LF:      if (fifo_wr) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready  = (r_state == ST_IDLE);
        o_busy   = (r_state != ST_IDLE);
        fifo_din = 8'h00;
        case (r_state)
`ifdef HEXFMT_PREFIX_EN
            ST_PREFIX0: fifo_din = CHAR_0;
            ST_PREFIX1: fifo_din = CHAR_X;
`endif
            ST_DIGIT:   fifo_din = w_digit;
            ST_CR:      fifo_din = CHAR_CR;
            ST_LF:      fifo_din = CHAR_LF;
            default:    fifo_din = 8'h00;
        endcase
    end

endmodule
